// File: rtl/throw_capture_sequencer_pkg.sv
// throw_capture_sequencer_pkg: state encoding and frame-end strobe shared with the HDMI controller
package throw_capture_sequencer_pkg;
    localparam int STATE_W = 3;
    typedef enum logic [STATE_W-1:0] {
        SETTLE   = 3'd0,
        ARMED    = 3'd1,
        WAIT_EOF = 3'd2,
        FROZEN   = 3'd3,
        JUDGE    = 3'd4,
        COOLDOWN = 3'd5
    } state_t;
    function automatic logic eof_hit(input int x, input int y, input int img_w, input int img_h);
        return (x == img_w * 2 - 1) && (y == img_h * 2 - 1);
    endfunction
endpackage

// File: rtl/throw_capture_sequencer_if.sv
// throw_capture_sequencer_if: display counters, camera gating and judgement handshake
interface throw_capture_sequencer_if #(
    parameter int H_MAX = 800,
    parameter int V_MAX = 525
);
    logic [$clog2(H_MAX)-1:0] x_pixel;
    logic [$clog2(V_MAX)-1:0] y_pixel;
    logic                     trig;
    logic                     cam_we_in;
    logic                     cam_we_out;
    logic                     freeze;
    logic                     judge_start;
    logic                     judge_done;
    logic                     busy;
    logic [15:0]              cap_count;
    logic                     err_timeout;
    logic [2:0]               state_dbg;
    modport master (
        output x_pixel, y_pixel, trig, cam_we_in, judge_done,
        input  cam_we_out, freeze, judge_start, busy, cap_count, err_timeout, state_dbg
    );
    modport slave (
        input  x_pixel, y_pixel, trig, cam_we_in, judge_done,
        output cam_we_out, freeze, judge_start, busy, cap_count, err_timeout, state_dbg
    );
endinterface

// File: rtl/throw_capture_sequencer_frame_event_counter.sv
// frame_event_counter: 8-bit eof counter with clear and terminal-count hit
module frame_event_counter (
    input  logic       pclk,
    input  logic       rstn,
    input  logic       clr,
    input  logic       inc,
    input  logic [7:0] target,
    output logic       hit
);
    logic [7:0] cnt;
    always_ff @(posedge pclk) begin
        if (!rstn || clr) cnt <= '0;
        else if (inc) cnt <= cnt + 8'd1;
    end
    assign hit = inc && (cnt == target);
endmodule

// File: rtl/throw_capture_sequencer.sv
// throw_capture_sequencer: freezes the frame buffer around a throw and paces judgement in frames
module throw_capture_sequencer
    import throw_capture_sequencer_pkg::*;
#(
    parameter int IMG_W           = 320,
    parameter int IMG_H           = 240,
    parameter int H_MAX           = 800,
    parameter int V_MAX           = 525,
    parameter int SETTLE_FRAMES   = 10,
    parameter int HOLD_FRAMES     = 30,
    parameter int JUDGE_TO_FRAMES = 60,
    parameter int COOL_FRAMES     = 15
) (
    input logic pclk,
    input logic rstn,
    throw_capture_sequencer_if.slave bus
);
    localparam int XW = $clog2(H_MAX);
    localparam int YW = $clog2(V_MAX);
    state_t        state, nxt;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          eof, hit, err_set;
    logic [7:0]    target;
    assign x   = bus.x_pixel;
    assign y   = bus.y_pixel;
    assign eof = eof_hit(int'(x), int'(y), IMG_W, IMG_H);
    assign target = state == SETTLE ? 8'(SETTLE_FRAMES - 1) :
                    state == FROZEN ? 8'(HOLD_FRAMES - 1) :
                    state == JUDGE  ? 8'(JUDGE_TO_FRAMES - 1) : 8'(COOL_FRAMES - 1);
    // Counter restarts on every state entry, so each state measures its own frames
    frame_event_counter u_fcnt (
        .pclk   (pclk),
        .rstn   (rstn),
        .clr    (nxt != state),
        .inc    (eof),
        .target (target),
        .hit    (hit)
    );
    always_comb begin
        nxt     = state;
        err_set = 1'b0;
        case (state)
            SETTLE:   nxt = hit ? ARMED : SETTLE;
            ARMED:    nxt = bus.trig ? WAIT_EOF : ARMED;
            WAIT_EOF: nxt = eof ? FROZEN : WAIT_EOF;
            FROZEN:   nxt = hit ? JUDGE : FROZEN;
            JUDGE: begin
                nxt     = (bus.judge_done || hit) ? COOLDOWN : JUDGE;
                err_set = hit && !bus.judge_done;
            end
            COOLDOWN: nxt = hit ? ARMED : COOLDOWN;
            default:  nxt = SETTLE;
        endcase
    end
    always_ff @(posedge pclk) begin
        if (!rstn) begin
            state           <= SETTLE;
            bus.freeze      <= 1'b0;
            bus.judge_start <= 1'b0;
            bus.busy        <= 1'b1;
            bus.cap_count   <= '0;
            bus.err_timeout <= 1'b0;
        end else begin
            state           <= nxt;
            bus.freeze      <= nxt == FROZEN || nxt == JUDGE;
            bus.judge_start <= state == FROZEN && nxt == JUDGE;
            bus.busy        <= nxt != ARMED;
            if (state == ARMED && bus.trig && bus.cap_count != 16'hFFFF)
                bus.cap_count <= bus.cap_count + 16'd1;
            if (err_set) bus.err_timeout <= 1'b1;
        end
    end
    assign bus.state_dbg  = state;
    assign bus.cam_we_out = bus.cam_we_in & ~bus.freeze;
endmodule

// File: tb/tb_throw_capture_sequencer.sv
// tb_throw_capture_sequencer: directed steps with hand-computed expectations
module tb_throw_capture_sequencer;
    logic pclk = 1'b0;
    logic rstn;
    int   n_cmp = 0;
    int   n_err = 0;
    always #5 pclk = ~pclk;
    throw_capture_sequencer_if #(.H_MAX(800), .V_MAX(525)) bus ();
    throw_capture_sequencer #(
        .IMG_W(320), .IMG_H(240), .H_MAX(800), .V_MAX(525),
        .SETTLE_FRAMES(2), .HOLD_FRAMES(3), .JUDGE_TO_FRAMES(4), .COOL_FRAMES(2)
    ) dut (
        .pclk (pclk),
        .rstn (rstn),
        .bus  (bus)
    );
    task automatic step(input int n = 1);
        repeat (n) @(posedge pclk);
        #1;
    endtask
    task automatic eofs(input int n);
        repeat (n) begin
            bus.x_pixel = 10'd639;
            bus.y_pixel = 10'd479;
            step();
            bus.x_pixel = '0;
            bus.y_pixel = '0;
        end
    endtask
    task automatic pulse_trig();
        bus.trig = 1'b1;
        step();
        bus.trig = 1'b0;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    initial begin
        rstn = 1'b0;
        bus.x_pixel = '0;
        bus.y_pixel = '0;
        bus.trig = 1'b0;
        bus.cam_we_in = 1'b1;
        bus.judge_done = 1'b0;
        step(2);
        chk("rst_state", 32'(bus.state_dbg), 0);
        chk("rst_freeze", 32'(bus.freeze), 0);
        chk("rst_busy", 32'(bus.busy), 1);
        chk("rst_cap", 32'(bus.cap_count), 0);
        chk("rst_err", 32'(bus.err_timeout), 0);
        chk("rst_jstart", 32'(bus.judge_start), 0);
        chk("rst_we", 32'(bus.cam_we_out), 1);
        rstn = 1'b1;
        step();
        // startup: triggers ignored while settling
        pulse_trig();
        chk("settle_cap", 32'(bus.cap_count), 0);
        chk("settle_state", 32'(bus.state_dbg), 0);
        eofs(1);
        pulse_trig();
        chk("settle_cap2", 32'(bus.cap_count), 0);
        chk("settle_state2", 32'(bus.state_dbg), 0);
        eofs(1);
        chk("armed_state", 32'(bus.state_dbg), 1);
        chk("armed_busy", 32'(bus.busy), 0);
        bus.judge_done = 1'b1;
        step();
        bus.judge_done = 1'b0;
        chk("jdone_ignored", 32'(bus.state_dbg), 1);
        // normal throw
        step();
        pulse_trig();
        chk("throw_cap", 32'(bus.cap_count), 1);
        chk("throw_state", 32'(bus.state_dbg), 2);
        chk("throw_busy", 32'(bus.busy), 1);
        pulse_trig();
        chk("wait_trig_cap", 32'(bus.cap_count), 1);
        chk("wait_freeze", 32'(bus.freeze), 0);
        eofs(1);
        chk("frozen_state", 32'(bus.state_dbg), 3);
        chk("frozen_freeze", 32'(bus.freeze), 1);
        chk("frozen_we", 32'(bus.cam_we_out), 0);
        pulse_trig();
        chk("frozen_trig_cap", 32'(bus.cap_count), 1);
        eofs(2);
        chk("hold_state", 32'(bus.state_dbg), 3);
        chk("hold_jstart", 32'(bus.judge_start), 0);
        eofs(1);
        chk("judge_state", 32'(bus.state_dbg), 4);
        chk("judge_start_hi", 32'(bus.judge_start), 1);
        step();
        chk("judge_start_lo", 32'(bus.judge_start), 0);
        chk("judge_freeze", 32'(bus.freeze), 1);
        bus.judge_done = 1'b1;
        step();
        bus.judge_done = 1'b0;
        chk("cool_state", 32'(bus.state_dbg), 5);
        chk("cool_freeze", 32'(bus.freeze), 0);
        chk("cool_we", 32'(bus.cam_we_out), 1);
        pulse_trig();
        chk("cool_trig_cap", 32'(bus.cap_count), 1);
        eofs(1);
        chk("cool_hold", 32'(bus.state_dbg), 5);
        eofs(1);
        chk("cool_exit", 32'(bus.state_dbg), 1);
        chk("normal_err", 32'(bus.err_timeout), 0);
        // trigger coincident with eof waits a full frame
        bus.trig = 1'b1;
        eofs(1);
        bus.trig = 1'b0;
        chk("coinc_state", 32'(bus.state_dbg), 2);
        chk("coinc_cap", 32'(bus.cap_count), 2);
        step(5);
        chk("coinc_freeze0", 32'(bus.freeze), 0);
        eofs(1);
        chk("coinc_freeze1", 32'(bus.freeze), 1);
        eofs(3);
        chk("coinc_judge", 32'(bus.state_dbg), 4);
        // judge_done on the timeout eof wins
        eofs(3);
        chk("pre_to_state", 32'(bus.state_dbg), 4);
        bus.judge_done = 1'b1;
        eofs(1);
        bus.judge_done = 1'b0;
        chk("tie_state", 32'(bus.state_dbg), 5);
        chk("tie_err", 32'(bus.err_timeout), 0);
        eofs(2);
        chk("tie_armed", 32'(bus.state_dbg), 1);
        // timeout
        pulse_trig();
        eofs(1);
        eofs(3);
        chk("to_judge", 32'(bus.state_dbg), 4);
        eofs(3);
        chk("to_wait_err", 32'(bus.err_timeout), 0);
        eofs(1);
        chk("to_state", 32'(bus.state_dbg), 5);
        chk("to_err", 32'(bus.err_timeout), 1);
        eofs(2);
        chk("to_armed", 32'(bus.state_dbg), 1);
        chk("to_err_sticky", 32'(bus.err_timeout), 1);
        chk("to_cap", 32'(bus.cap_count), 3);
        // reset mid-FROZEN
        pulse_trig();
        eofs(1);
        chk("prerst_freeze", 32'(bus.freeze), 1);
        rstn = 1'b0;
        step();
        chk("mrst_freeze", 32'(bus.freeze), 0);
        chk("mrst_state", 32'(bus.state_dbg), 0);
        chk("mrst_cap", 32'(bus.cap_count), 0);
        chk("mrst_err", 32'(bus.err_timeout), 0);
        chk("mrst_we1", 32'(bus.cam_we_out), 1);
        bus.cam_we_in = 1'b0;
        #1;
        chk("mrst_we0", 32'(bus.cam_we_out), 0);
        bus.cam_we_in = 1'b1;
        rstn = 1'b1;
        step();
        // saturation from a preloaded count
        eofs(2);
        chk("sat_armed", 32'(bus.state_dbg), 1);
        force bus.cap_count = 16'hFFFE;
        #1;
        release bus.cap_count;
        pulse_trig();
        chk("sat_ffff", 32'(bus.cap_count), 32'hFFFF);
        eofs(4);
        bus.judge_done = 1'b1;
        step();
        bus.judge_done = 1'b0;
        eofs(2);
        chk("sat_armed2", 32'(bus.state_dbg), 1);
        pulse_trig();
        chk("sat_hold", 32'(bus.cap_count), 32'hFFFF);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
